// File: rtl/rd_resp_engine.sv
// Burst read-response engine: queues read requests, fetches words from a synchronous SRAM
// and streams them out with a two-entry credit-protected skid buffer.
module rd_resp_engine #(
  parameter int AW           = 32,
  parameter int DW           = 64,
  parameter int MEM_AW       = 16,
  parameter int AQ_DEPTH     = 2,
  parameter int MAX_LEN_LOG2 = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     araddr_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  input  logic [3:0]        arburst_i,
  output logic [DW-1:0]     rdata_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic              rlast_o,
  output logic              mem_en_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic [DW-1:0]     mem_rdata_i,
  output logic              busy_o,
  output logic              fsm_state_o
);

  localparam int QAW  = $clog2(AQ_DEPTH);
  localparam int LENW = $clog2(MAX_LEN_LOG2 + 1);
  localparam int BLW  = MAX_LEN_LOG2 + 1;

  typedef enum logic {IDLE, BURST} state_t;

  // Handshakes (both channels): a transfer happens on a rising edge where valid & ready;
  // the producer holds payload stable while valid & ~ready.

  logic              init_q;
  logic [QAW:0]      wr_ptr_q, rd_ptr_q;
  logic [MEM_AW-1:0] q_addr_q [AQ_DEPTH];
  logic [LENW-1:0]   q_len_q  [AQ_DEPTH];
  logic              q_empty, q_full, q_push, q_pop;
  logic [LENW-1:0]   len_in;

  state_t            state_q;
  logic [MEM_AW-1:0] cur_addr_q;
  logic [BLW-1:0]    beats_left_q;
  logic              credit_ok, issue;

  logic              inflight_q, inflight_last_q;
  logic [DW-1:0]     buf_data_q [2];
  logic [1:0]        buf_last_q;
  logic              buf_rd_q, buf_wr_q;
  logic [1:0]        buf_cnt_q;
  logic              beat_hs, buf_push, buf_pop;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^araddr_i[AW-1:MEM_AW];

  // Request queue
  assign q_empty   = (wr_ptr_q == rd_ptr_q);
  assign q_full    = (wr_ptr_q[QAW] != rd_ptr_q[QAW]) &&
                     (wr_ptr_q[QAW-1:0] == rd_ptr_q[QAW-1:0]);
  assign arready_o = init_q & ~q_full;
  assign q_push    = arvalid_i & arready_o;
  assign q_pop     = (state_q == IDLE) & ~q_empty;

  always_comb begin
    len_in = arburst_i[LENW-1:0];
    if (arburst_i > 4'(MAX_LEN_LOG2)) len_in = LENW'(MAX_LEN_LOG2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      init_q <= 1'b1;
      if (q_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (q_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (q_push) begin
      q_addr_q[wr_ptr_q[QAW-1:0]] <= araddr_i[MEM_AW-1:0];
      q_len_q[wr_ptr_q[QAW-1:0]]  <= len_in;
    end
  end

  // Reads are issued only while buffered + in-flight beats leave a free buffer slot.
  assign credit_ok = ({1'b0, buf_cnt_q} + {2'b00, inflight_q}) < 3'd2;
  assign issue     = (state_q == BURST) & credit_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!q_empty) begin
            cur_addr_q   <= q_addr_q[rd_ptr_q[QAW-1:0]];
            beats_left_q <= BLW'(1) << q_len_q[rd_ptr_q[QAW-1:0]];
            state_q      <= BURST;
          end
        end
        BURST: begin
          if (issue) begin
            cur_addr_q   <= cur_addr_q + 1'b1;
            beats_left_q <= beats_left_q - 1'b1;
            if (beats_left_q == BLW'(1)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en_o    = issue;
  assign mem_addr_o  = cur_addr_q;
  assign fsm_state_o = (state_q == BURST);

  // Output: buffered beats are older than the in-flight read, which bypasses when the buffer is empty.
  assign rvalid_o = (buf_cnt_q != 2'd0) | inflight_q;
  assign rdata_o  = (buf_cnt_q != 2'd0) ? buf_data_q[buf_rd_q] : mem_rdata_i;
  assign rlast_o  = rvalid_o & ((buf_cnt_q != 2'd0) ? buf_last_q[buf_rd_q] : inflight_last_q);
  assign beat_hs  = rvalid_o & rready_i;
  assign buf_pop  = beat_hs & (buf_cnt_q != 2'd0);
  assign buf_push = inflight_q & ~(beat_hs & (buf_cnt_q == 2'd0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      buf_last_q      <= '0;
      buf_rd_q        <= 1'b0;
      buf_wr_q        <= 1'b0;
      buf_cnt_q       <= '0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= (beats_left_q == BLW'(1));
      if (buf_push) begin
        buf_last_q[buf_wr_q] <= inflight_last_q;
        buf_wr_q             <= ~buf_wr_q;
      end
      if (buf_pop) buf_rd_q <= ~buf_rd_q;
      buf_cnt_q <= buf_cnt_q + 2'(buf_push) - 2'(buf_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (buf_push) buf_data_q[buf_wr_q] <= mem_rdata_i;
  end

  assign busy_o = ~q_empty | (state_q == BURST) | (buf_cnt_q != 2'd0) | inflight_q;

endmodule

// File: tb/tb_rd_resp_engine.sv
// Directed bench for rd_resp_engine: SRAM model with mem[i]=i, scoreboard of expected
// beats and SRAM addresses, plus hold-stability and credit checks on every cycle.
module tb_rd_resp_engine;
  localparam int DW = 64;
  localparam int W  = DW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [3:0]    arburst = '0;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rready = 1'b1;
  logic          rlast;
  logic          mem_en;
  logic [15:0]   mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          fsm_state;

  rd_resp_engine dut (
    .clk(clk), .rst_n(rst_n), .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
    .arburst_i(arburst), .rdata_o(rdata), .rvalid_o(rvalid), .rready_i(rready),
    .rlast_o(rlast), .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
    .busy_o(busy), .fsm_state_o(fsm_state)
  );

  // Clock, cycle counter and SRAM model
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [0:65535];
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  logic [15:0]  addr_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int issued = 0;
  int retired = 0;
  int beats_seen = 0;
  int last_cyc = 0;
  logic         stall_prev = 1'b0;
  logic [W-1:0] prev_beat = '0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: post one request, wait for acceptance, then queue its expected beats and addresses.
  task automatic send(input logic [31:0] a, input logic [3:0] b, output int t);
    bit ok;
    int len;
    int n;
    logic [15:0] ad;
    ok = 1'b0;
    t = 0;
    araddr = a;
    arburst = b;
    arvalid = 1'b1;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (arready) begin
        ok = 1'b1;
        t = cyc;
      end
      step();
    end
    arvalid = 1'b0;
    chk("ar_accept", W'(ok), W'(1));
    if (ok) begin
      len = (b > 4'd5) ? 5 : int'(b);
      n = 1 << len;
      for (int i = 0; i < n; i++) begin
        ad = 16'(a + 32'(i));
        exp_q.push_back({(i == n - 1), 48'h0, ad});
        addr_q.push_back(ad);
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    bit done;
    done = 1'b0;
    for (int k = 0; k < bound && !done; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && addr_q.size() == 0) done = 1'b1;
    end
    chk("idle_reached", W'(done), W'(1));
  endtask

  // Monitor: SRAM address order, credit limit, stall stability, beat scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      addr_q.delete();
      issued = 0;
      retired = 0;
      stall_prev = 1'b0;
    end else begin
      if (mem_en) begin
        chk("credit", W'((issued - retired) < 2), W'(1));
        if (addr_q.size() == 0) chk("mem_en_unexpected", W'(1), W'(0));
        else chk("mem_addr", W'(mem_addr), W'(addr_q.pop_front()));
      end
      if (stall_prev) begin
        chk("hold_valid", W'(rvalid), W'(1));
        chk("hold_beat", {rlast, rdata}, prev_beat);
      end
      if (rvalid && rready) begin
        if (exp_q.size() == 0) chk("beat_unexpected", {rlast, rdata}, 'x);
        else chk("beat", {rlast, rdata}, exp_q.pop_front());
        beats_seen++;
        if (rlast) last_cyc = cyc;
      end
      stall_prev = rvalid & ~rready;
      prev_beat = {rlast, rdata};
      issued += int'(mem_en);
      retired += int'(rvalid & rready);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int base;
    logic [3:0] pat;
    for (int i = 0; i < 65536; i++) mem[i] = DW'(i);

    // Reset
    repeat (3) step();
    @(negedge clk);
    chk("rst_arready", W'(arready), W'(0));
    chk("rst_rvalid", W'(rvalid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_mem_en", W'(mem_en), W'(0));
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("post_rst_arready", W'(arready), W'(1));
    chk("post_rst_rvalid", W'(rvalid), W'(0));
    chk("post_rst_busy", W'(busy), W'(0));

    // 1: single beat latency
    step();
    send(32'h40, 4'd0, t);
    @(negedge clk);
    @(negedge clk);
    chk("t1_rvalid_T2", W'(rvalid), W'(0));
    chk("t1_busy_T2", W'(busy), W'(1));
    @(negedge clk);
    chk("t1_rvalid_T3", W'(rvalid), W'(1));
    chk("t1_beat_T3", {rlast, rdata}, {1'b1, 64'h40});
    @(negedge clk);
    chk("t1_busy_T4", W'(busy), W'(0));

    // 2: 32-beat burst at full rate
    step();
    send(32'h100, 4'd5, t);
    wait_idle(200);
    chk("t2_rlast_cycle", W'(last_cyc), W'(t + 34));

    // 3: same burst with rready pattern 1,0,0,1
    step();
    pat = 4'b1001;
    fork
      send(32'h100, 4'd5, t);
      for (int k = 0; k < 200; k++) begin
        rready = pat[k % 4];
        step();
      end
    join
    rready = 1'b1;
    wait_idle(200);

    // 4: three queued requests
    step();
    send(32'h0, 4'd1, t);
    send(32'h20, 4'd2, t);
    send(32'h40, 4'd0, t);
    @(negedge clk);
    chk("t4_arready_full", W'(arready), W'(0));
    wait_idle(200);

    // 5: address wrap and burst-code clamp
    step();
    send(32'hFFFE, 4'd2, t);
    wait_idle(100);
    step();
    base = beats_seen;
    send(32'h500, 4'd9, t);
    wait_idle(200);
    chk("t5_clamp_beats", W'(beats_seen - base), W'(32));

    // 6: reset during beat 10
    step();
    base = beats_seen;
    send(32'h200, 4'd5, t);
    for (int k = 0; k < 200 && beats_seen < base + 10; k++) @(negedge clk);
    chk("t6_reached_beat10", W'(beats_seen >= base + 10), W'(1));
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rvalid_after_rst", W'(rvalid), W'(0));
    chk("t6_busy_after_rst", W'(busy), W'(0));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t6_no_stale", W'(rvalid | mem_en), W'(0));
    end
    step();
    send(32'h300, 4'd1, t);
    wait_idle(100);

    chk("leftover_beats", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
